// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 convolutional encoder with two zero tail bits per frame.
// Optional macro CONV_ERR_INJ_EN adds err_mask_i, XORed into each loaded symbol.
module conv_encoder #(
   parameter logic [2:0]  G0    = 3'b111,
   parameter logic [2:0]  G1    = 3'b101,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic             s_data_i,
   input  logic             s_last_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [1:0]       m_sym_o,
   output logic             m_last_o,
   output logic [CNT_W-1:0] frame_len_o,
`ifdef CONV_ERR_INJ_EN
   input  logic [1:0]       err_mask_i,
`endif
   output logic             busy_o
);
   typedef enum logic [1:0] {IDLE, DATA, TAIL} fsm_e;
   fsm_e             fsm_q;
   logic [1:0]       state_q;
   logic             tail_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] frame_len_q;
   logic             m_valid_q;
   logic [1:0]       m_sym_q;
   logic             m_last_q;
   logic             free;
   logic             accept;
   logic             tail_ld;
   logic             load;
   logic             u;
   logic [2:0]       taps;
   logic [1:0]       mask;
   logic [1:0]       sym_d;
`ifdef CONV_ERR_INJ_EN
   assign mask = err_mask_i;
`else
   assign mask = 2'b00;
`endif
   assign free      = !m_valid_q || m_ready_i;
   assign s_ready_o = (fsm_q != TAIL) && free;
   assign accept    = s_valid_i && s_ready_o;
   assign tail_ld   = (fsm_q == TAIL) && free;
   assign load      = accept || tail_ld;
   assign u         = accept ? s_data_i : 1'b0;
   assign taps      = {u, state_q};
   // mask only corrupts the emitted symbol; the trellis state stays clean
   assign sym_d     = {^(G0 & taps), ^(G1 & taps)} ^ mask;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fsm_q       <= IDLE;
         state_q     <= 2'b00;
         tail_q      <= 1'b0;
         cnt_q       <= '0;
         frame_len_q <= '0;
         m_valid_q   <= 1'b0;
         m_sym_q     <= 2'b00;
         m_last_q    <= 1'b0;
      end else begin
         if (load) begin
            m_valid_q <= 1'b1;
            m_sym_q   <= sym_d;
            m_last_q  <= tail_ld && tail_q;
            state_q   <= {u, state_q[1]};
         end else if (m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
         end
         if (accept) begin
            cnt_q <= (fsm_q == IDLE) ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
            fsm_q <= s_last_i ? TAIL : DATA;
         end else if (tail_ld) begin
            tail_q <= ~tail_q;
            if (tail_q) begin
               fsm_q       <= IDLE;
               frame_len_q <= cnt_q;
            end
         end
      end
   end
   assign m_valid_o   = m_valid_q;
   assign m_sym_o     = m_sym_q;
   assign m_last_o    = m_last_q;
   assign frame_len_o = frame_len_q;
   assign busy_o      = fsm_q != IDLE;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed frames with hand-computed symbol sequences for conv_encoder.
module tb_conv_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_data = 1'b0;
   logic        s_last = 1'b0;
   logic        m_ready = 1'b1;
   logic        s_ready_o;
   logic        m_valid_o;
   logic [1:0]  m_sym_o;
   logic        m_last_o;
   logic [15:0] frame_len_o;
   logic        busy_o;
`ifdef CONV_ERR_INJ_EN
   logic [1:0]  err_mask = 2'b00;
`endif
   int n_checks = 0;
   int n_fail = 0;
   logic [1:0]  q_sym[$];
   logic        q_last[$];
   logic [15:0] q_flen[$];

   conv_encoder dut (
      .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
      .s_data_i(s_data), .s_last_i(s_last), .m_valid_o(m_valid_o), .m_ready_i(m_ready),
      .m_sym_o(m_sym_o), .m_last_o(m_last_o), .frame_len_o(frame_len_o),
`ifdef CONV_ERR_INJ_EN
      .err_mask_i(err_mask),
`endif
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // inputs only change just after posedge, so the negedge view decides the next transfer
   always @(negedge clk) begin
      if (rst_n && m_valid_o && m_ready) begin
         q_sym.push_back(m_sym_o);
         q_last.push_back(m_last_o);
         q_flen.push_back(frame_len_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      q_sym.delete();
      q_last.delete();
      q_flen.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [7:0] l, input int n);
      logic ok;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = d[i];
         s_last  = l[i];
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready_o;
            @(posedge clk);
            #1;
         end
         if (!ok) check("send_timeout", 0, 1);
      end
      s_valid = 1'b0;
      s_data  = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int n, input logic [15:0] syms,
                              input logic [7:0] lasts, input logic [15:0] flen);
      logic [15:0] s;
      logic [7:0]  l;
      s = syms;
      l = lasts;
      for (int t = 0; t < 50 && q_sym.size() < n; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("%s_count", tag), q_sym.size(), n);
      for (int k = 0; k < n && k < q_sym.size(); k++) begin
         check($sformatf("%s_sym%0d", tag, k), q_sym[k], s[2*k +: 2]);
         check($sformatf("%s_last%0d", tag, k), q_last[k], l[k]);
      end
      if (q_flen.size() >= n) check($sformatf("%s_flen", tag), q_flen[n-1], flen);
      @(negedge clk);
      check($sformatf("%s_idle", tag), busy_o, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_valid", m_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_sym", m_sym_o, 0);
      check("rst_last", m_last_o, 0);
      check("rst_flen", frame_len_o, 0);
      check("rst_ready", s_ready_o, 1);
      @(posedge clk);
      #1;

      clear_q();
      send_frame(8'h0D, 8'h08, 4);
      check_frame("basic", 6, 16'h0D4B, 8'h20, 16'd4);

      clear_q();
      fork
         send_frame(8'h0D, 8'h08, 4);
         begin
            repeat (2) @(posedge clk);
            #1 m_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check($sformatf("stall_valid%0d", c), m_valid_o, 1);
               check($sformatf("stall_sym%0d", c), m_sym_o, 2'b10);
               check($sformatf("stall_sready%0d", c), s_ready_o, 0);
               @(posedge clk);
            end
            #1 m_ready = 1'b1;
         end
      join
      check_frame("bp", 6, 16'h0D4B, 8'h20, 16'd4);

      clear_q();
      send_frame(8'h01, 8'h01, 1);
      check_frame("single", 3, 16'h003B, 8'h04, 16'd1);

      send_frame(8'h03, 8'h00, 2);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mrst_valid", m_valid_o, 0);
      check("mrst_busy", busy_o, 0);
      check("mrst_flen", frame_len_o, 0);
      @(posedge clk);
      #1;
      clear_q();
      send_frame(8'h01, 8'h01, 1);
      check_frame("mrst", 3, 16'h003B, 8'h04, 16'd1);

      clear_q();
      send_frame(8'h04, 8'h06, 3);
      check_frame("b2b", 7, 16'h3B00, 8'h48, 16'd1);
      if (q_flen.size() >= 4) check("b2b_flen_first", q_flen[3], 16'd2);

`ifdef CONV_ERR_INJ_EN
      clear_q();
      err_mask = 2'b10;
      fork
         send_frame(8'h0D, 8'h08, 4);
         begin
            @(posedge clk);
            #1 err_mask = 2'b00;
         end
      join
      check_frame("errinj", 6, 16'h0D49, 8'h20, 16'd4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
